ins_encoder_loader: RTL

- Encodes RV32I instructions from decoded fields (opcode, rd, funct3, rs1, rs2, funct7, immediate, format tag) into 32-bit instruction words.
- Streams the encoded words into instruction memory at consecutive word addresses.
- Used by testbenches and the boot path to preload programs for the single-cycle core.
- Accepts one instruction per cycle through a valid/ready handshake and issues one registered memory write per accepted legal instruction.

---
 rtl/ins_encoder_loader_pkg.sv | 16 +
 rtl/ins_encoder_loader_enc.sv | 32 +++
 rtl/ins_encoder_loader.sv | 95 +++++++++
 3 files changed

// File: rtl/ins_encoder_loader_pkg.sv
// ins_encoder_loader_pkg: shared format codes, FSM states and RV32I opcodes
package ins_encoder_loader_pkg;
    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;
    localparam logic [6:0] OP_R = 7'h33;
    localparam logic [6:0] OP_I = 7'h13;
    localparam logic [6:0] OP_S = 7'h23;
    localparam logic [6:0] OP_B = 7'h63;
    localparam logic [6:0] OP_U = 7'h37;
    localparam logic [6:0] OP_J = 7'h6F;
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;
endpackage

// File: rtl/ins_encoder_loader_enc.sv
// ins_encoder: combinational RV32I word assembly from decoded fields
module ins_encoder
    import ins_encoder_loader_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        illegal,
    output logic        misaligned
);
    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (fmt)
            FMT_R:   word = {funct7, rs2, rs1, funct3, rd, opcode};
            FMT_I:   word = {imm[11:0], rs1, funct3, rd, opcode};
            FMT_S:   word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            FMT_B:   word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            FMT_U:   word = {imm[31:12], rd, opcode};
            FMT_J:   word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            default: illegal = 1'b1;
        endcase
    end
    // B/J offsets are halfword-aligned; bit 0 is simply dropped from the word
    assign misaligned = (fmt == FMT_B || fmt == FMT_J) && imm[0];
endmodule

// File: rtl/ins_encoder_loader.sv
// ins_encoder_loader: accepts field bundles, encodes them and streams words
// into instruction memory at consecutive addresses with one-cycle latency.
module ins_encoder_loader
    import ins_encoder_loader_pkg::*;
#(
    parameter int DEPTH     = 64,
    parameter int ADDR_W    = 32,
    parameter int BASE_ADDR = 0,
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [2:0]        funct3,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [CW-1:0]     count,
    output logic              busy,
    output logic              done,
    output logic              err
);
    state_e            r_state, w_next;
    logic [CW-1:0]     r_count;
    logic              r_we, r_err;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata, w_word;
    logic              w_illegal, w_misaligned, w_accept, w_start;

    ins_encoder u_enc (
        .fmt(fmt), .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1),
        .rs2(rs2), .funct7(funct7), .imm(imm), .word(w_word),
        .illegal(w_illegal), .misaligned(w_misaligned)
    );

    assign in_ready = (r_state == LOAD) && (r_count < CW'(DEPTH));
    assign w_accept = in_valid && in_ready;
    assign w_start  = start && (r_state != LOAD);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = start ? LOAD : IDLE;
            LOAD:    w_next = (finish || (w_accept && !w_illegal && r_count == CW'(DEPTH - 1))) ? DONE : LOAD;
            DONE:    w_next = start ? LOAD : DONE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_count <= '0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= ADDR_W'(BASE_ADDR);
            r_wdata <= '0;
        end else begin
            r_state <= w_next;
            r_we    <= 1'b0;
            if (w_start) begin
                r_count <= '0;
                r_err   <= 1'b0;
            end else if (w_accept) begin
                if (w_illegal) begin
                    r_err <= 1'b1;
                end else begin
                    r_we    <= 1'b1;
                    r_addr  <= ADDR_W'(BASE_ADDR) + ADDR_W'({r_count, 2'b00});
                    r_wdata <= w_word;
                    r_count <= r_count + 1'b1;
                    if (w_misaligned) r_err <= 1'b1;
                end
            end
        end
    end

    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign count     = r_count;
    assign err       = r_err;
    assign busy      = (r_state == LOAD);
    assign done      = (r_state == DONE);
endmodule
